// File: rtl/reset_sequencer.sv
// Staged reset generator for the processor subsystem: power-on reset, then system/bus reset.
// Optional build macro LOCKUP_RESET_EN turns CPU LOCKUP into a soft reset with cause code 3.
module reset_sequencer #(
  parameter int LOCK_CYCLES     = 16,
  parameter int SYS_DELAY       = 8,
  parameter int SOFT_RST_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic       hclk,
  input  logic       ext_reset_n,
  input  logic       clk_locked,
  input  logic       sys_reset_req,
  input  logic       lockup,
  output logic       poreset_n,
  output logic       hreset_n,
  output logic [1:0] reset_cause,
  output logic       rst_busy
);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    PO_REL,
    RUN,
    SOFT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYS_LAST  = CNT_W'(SYS_DELAY - 1);
  localparam logic [CNT_W-1:0] SOFT_LAST = CNT_W'(SOFT_RST_CYCLES - 1);

  localparam logic [1:0] CAUSE_EXT    = 2'd0;
  localparam logic [1:0] CAUSE_LOCK   = 2'd1;
  localparam logic [1:0] CAUSE_SYSREQ = 2'd2;
  localparam logic [1:0] CAUSE_LOCKUP = 2'd3;

  logic [1:0]       rst_sync_reg;
  logic [1:0]       lock_sync_reg;
  logic             rst_s;
  logic             locked_s;
  logic             lockup_req;
  logic             lock_lost;
  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_inc;

`ifdef LOCKUP_RESET_EN
  assign lockup_req = lockup;
`else
  logic unused_lockup;
  assign unused_lockup = lockup;
  assign lockup_req    = 1'b0;
`endif

  // Both synchronisers are cleared by the board reset so a stale lock cannot leak past it.
  always_ff @(posedge hclk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      rst_sync_reg  <= 2'b00;
      lock_sync_reg <= 2'b00;
    end else begin
      rst_sync_reg  <= {rst_sync_reg[0], 1'b1};
      lock_sync_reg <= {lock_sync_reg[0], clk_locked};
    end
  end

  assign rst_s     = rst_sync_reg[1];
  assign locked_s  = lock_sync_reg[1];
  assign cnt_inc   = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CNT_ONE;
  assign lock_lost = !locked_s &&
                     (state_reg == PO_REL || state_reg == RUN || state_reg == SOFT);

  always_ff @(posedge hclk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_reg   <= HOLD;
      cnt_reg     <= CNT_ZERO;
      poreset_n   <= 1'b0;
      hreset_n    <= 1'b0;
      reset_cause <= CAUSE_EXT;
      rst_busy    <= 1'b1;
    end else if (lock_lost) begin
      state_reg   <= WAIT_LOCK;
      cnt_reg     <= CNT_ZERO;
      poreset_n   <= 1'b0;
      hreset_n    <= 1'b0;
      reset_cause <= CAUSE_LOCK;
      rst_busy    <= 1'b1;
    end else begin
      case (state_reg)
        HOLD: begin
          if (rst_s) begin
            state_reg <= WAIT_LOCK;
            cnt_reg   <= CNT_ZERO;
          end
        end
        WAIT_LOCK: begin
          if (!locked_s) begin
            cnt_reg <= CNT_ZERO;
          end else if (cnt_reg == LOCK_LAST) begin
            state_reg <= PO_REL;
            cnt_reg   <= CNT_ZERO;
            poreset_n <= 1'b1;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        PO_REL: begin
          if (cnt_reg == SYS_LAST) begin
            state_reg <= RUN;
            cnt_reg   <= CNT_ZERO;
            hreset_n  <= 1'b1;
            rst_busy  <= 1'b0;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        RUN: begin
          // LOCKUP outranks SYSRESETREQ when both arrive on the same edge.
          if (lockup_req) begin
            state_reg   <= SOFT;
            cnt_reg     <= CNT_ZERO;
            hreset_n    <= 1'b0;
            reset_cause <= CAUSE_LOCKUP;
            rst_busy    <= 1'b1;
          end else if (sys_reset_req) begin
            state_reg   <= SOFT;
            cnt_reg     <= CNT_ZERO;
            hreset_n    <= 1'b0;
            reset_cause <= CAUSE_SYSREQ;
            rst_busy    <= 1'b1;
          end
        end
        SOFT: begin
          if (cnt_reg == SOFT_LAST) begin
            state_reg <= PO_REL;
            cnt_reg   <= CNT_ZERO;
          end else begin
            cnt_reg <= cnt_inc;
          end
        end
        default: begin
          state_reg <= HOLD;
          cnt_reg   <= CNT_ZERO;
          poreset_n <= 1'b0;
          hreset_n  <= 1'b0;
          rst_busy  <= 1'b1;
        end
      endcase
    end
  end

endmodule
